// File: rtl/ofdm_sym_scheduler.sv
// Frame sequencer ahead of pilot insertion: forwards TRN_SYMS training symbols
// from source T, then NSYM data symbols from source D, each symbol in its own
// CYC_O burst separated by a GAP_CYC-cycle idle gap.
module ofdm_sym_scheduler #(
  parameter int TRN_LEN  = 256,
  parameter int DAT_LEN  = 192,
  parameter int TRN_SYMS = 2,
  parameter int GAP_CYC  = 2,
  parameter int NSYM_W   = 10
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              START_I,
  input  logic [NSYM_W-1:0] NSYM_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  input  logic [31:0]       T_DAT_I,
  input  logic              T_STB_I,
  output logic              T_ACK_O,
  input  logic [31:0]       D_DAT_I,
  input  logic              D_STB_I,
  output logic              D_ACK_O,
  output logic [31:0]       DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I
);

  localparam int SMP_MAX = (TRN_LEN > DAT_LEN) ? TRN_LEN : DAT_LEN;
  localparam int SMP_W   = $clog2(SMP_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam logic [SMP_W-1:0]    TRN_LAST   = SMP_W'(TRN_LEN - 1);
  localparam logic [SMP_W-1:0]    DAT_LAST   = SMP_W'(DAT_LEN - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [NSYM_W+1:0]   TRN_SYMS_X = (NSYM_W+2)'(TRN_SYMS);

  typedef enum logic [1:0] {IDLE, TRN, DAT, GAP} state_t;

  state_t              state_q, state_d;
  logic [NSYM_W-1:0]   nsym_q, nsym_d;
  logic [NSYM_W:0]     sym_cnt_q, sym_cnt_d;
  logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                cyc_q, cyc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sel_t, sel_d, src_stb, hs;
  logic [NSYM_W+1:0]   sym_x, sym_end;

  // Zero-latency datapath: mux the granted source onto the downstream bus
  always_comb begin
    sel_t   = (state_q == TRN);
    sel_d   = (state_q == DAT);
    DAT_O   = '0;
    src_stb = 1'b0;
    if (sel_t) begin
      DAT_O   = T_DAT_I;
      src_stb = T_STB_I;
    end else if (sel_d) begin
      DAT_O   = D_DAT_I;
      src_stb = D_STB_I;
    end
    STB_O   = cyc_q & src_stb;
    WE_O    = STB_O;
    hs      = STB_O & ACK_I;
    T_ACK_O = hs & sel_t;
    D_ACK_O = hs & sel_d;
  end

  assign CYC_O   = cyc_q;
  assign BUSY_O  = busy_q;
  assign DONE_O  = done_q;
  assign sym_x   = {1'b0, sym_cnt_q};
  assign sym_end = TRN_SYMS_X + {2'b00, nsym_q};

  // Frame sequencing: symbol/sample/gap counters and registered envelope flags
  always_comb begin
    state_d   = state_q;
    nsym_d    = nsym_q;
    sym_cnt_d = sym_cnt_q;
    smp_cnt_d = smp_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cyc_d     = cyc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START_I) begin
          nsym_d    = NSYM_I;
          sym_cnt_d = '0;
          smp_cnt_d = '0;
          gap_cnt_d = '0;
          cyc_d     = 1'b1;
          busy_d    = 1'b1;
          state_d   = TRN;
        end
      end
      TRN, DAT: begin
        if (hs) begin
          if (smp_cnt_q == (sel_t ? TRN_LAST : DAT_LAST)) begin
            smp_cnt_d = '0;
            sym_cnt_d = sym_cnt_q + 1'b1;
            gap_cnt_d = '0;
            cyc_d     = 1'b0;
            state_d   = GAP;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (sym_x < TRN_SYMS_X) begin
            cyc_d   = 1'b1;
            state_d = TRN;
          end else if (sym_x < sym_end) begin
            cyc_d   = 1'b1;
            state_d = DAT;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight without a DONE pulse
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      nsym_q    <= '0;
      sym_cnt_q <= '0;
      smp_cnt_q <= '0;
      gap_cnt_q <= '0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nsym_q    <= nsym_d;
      sym_cnt_q <= sym_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ofdm_sym_scheduler.sv
// Bench for ofdm_sym_scheduler: table of frame scenarios plus hand-written
// reset/abort and back-to-back sequences; a queue scoreboard holds the
// expected sample stream for each frame.
module tb_ofdm_sym_scheduler;
  localparam int TRN_LEN  = 256;
  localparam int DAT_LEN  = 192;
  localparam int TRN_SYMS = 2;
  localparam int GAP_CYC  = 2;
  localparam int NSYM_W   = 10;
  localparam logic [31:0] T_BASE = 32'h5A00_0000;
  localparam logic [31:0] D_BASE = 32'hC300_0000;

  logic              CLK_I, RST_I, START_I;
  logic [NSYM_W-1:0] NSYM_I;
  logic              BUSY_O, DONE_O;
  logic [31:0]       T_DAT_I, D_DAT_I, DAT_O;
  logic              T_STB_I, T_ACK_O, D_STB_I, D_ACK_O;
  logic              CYC_O, STB_O, WE_O, ACK_I;

  ofdm_sym_scheduler #(.TRN_LEN(TRN_LEN), .DAT_LEN(DAT_LEN), .TRN_SYMS(TRN_SYMS),
                       .GAP_CYC(GAP_CYC), .NSYM_W(NSYM_W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .NSYM_I(NSYM_I),
    .BUSY_O(BUSY_O), .DONE_O(DONE_O),
    .T_DAT_I(T_DAT_I), .T_STB_I(T_STB_I), .T_ACK_O(T_ACK_O),
    .D_DAT_I(D_DAT_I), .D_STB_I(D_STB_I), .D_ACK_O(D_ACK_O),
    .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  typedef struct {
    int nsym;
    bit rnd;
    int inj;     // wait-cycle index at which a stray START(NSYM=7) is pulsed; 0 = none
    int t_exp;
    int d_exp;
  } vec_t;

  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  int          bursts_smp[$], bursts_cyc[$], gaps[$];
  int          hi_run = 0, lo_run = 0, hs_run = 0;
  logic        cyc_prev = 1'b0, busy_prev = 1'b0;
  int          t_acks, d_acks, done_cnt, busy_gap;
  bit          in_frame = 0, rnd = 0, t_hs = 0, d_hs = 0;
  int          t_idx = 0, d_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Observe the bus mid-cycle: scoreboard pops, burst/gap accounting
  task automatic sample();
    t_hs = T_ACK_O;
    d_hs = D_ACK_O;
    if (T_ACK_O === 1'b1) t_acks++;
    if (D_ACK_O === 1'b1) d_acks++;
    if (T_ACK_O === 1'b1 || D_ACK_O === 1'b1)
      chk("ack_qual", 32'({T_ACK_O & D_ACK_O, ~ACK_I}), 32'd0);
    if (STB_O === 1'b1 || WE_O === 1'b1) chk("we_eq_stb", 32'(WE_O), 32'(STB_O));
    if (STB_O === 1'b1 && ACK_I === 1'b1) begin
      hs_run++;
      if (exp_q.size() == 0) chk("extra_sample", DAT_O, 32'hFFFF_FFFF);
      else chk("dat_o", DAT_O, exp_q.pop_front());
    end
    if (DONE_O === 1'b1) begin
      done_cnt++;
      chk("done_busy_low", 32'(BUSY_O), 32'd0);
    end
    if (in_frame && BUSY_O !== 1'b1 && DONE_O !== 1'b1) busy_gap++;
    if (CYC_O === 1'b1) begin
      if (cyc_prev !== 1'b1 && busy_prev === 1'b1) gaps.push_back(lo_run);
      hi_run = (cyc_prev === 1'b1) ? hi_run + 1 : 1;
    end else begin
      if (cyc_prev === 1'b1) begin
        bursts_smp.push_back(hs_run);
        bursts_cyc.push_back(hi_run);
        hs_run = 0;
        lo_run = 1;
      end else lo_run++;
    end
    cyc_prev  = CYC_O;
    busy_prev = BUSY_O;
  endtask

  // One clock: sample at the falling edge, drive new inputs just after the rising edge
  task automatic step();
    @(negedge CLK_I);
    sample();
    @(posedge CLK_I);
    #1;
    if (t_hs) t_idx++;
    if (d_hs) d_idx++;
    T_DAT_I = T_BASE | 32'(t_idx);
    D_DAT_I = D_BASE | 32'(d_idx);
    if (rnd) begin
      T_STB_I = 1'($urandom_range(0, 1));
      D_STB_I = 1'($urandom_range(0, 1));
      ACK_I   = 1'($urandom_range(0, 1));
    end else begin
      T_STB_I = 1'b1;
      D_STB_I = 1'b1;
      ACK_I   = 1'b1;
    end
  endtask

  task automatic begin_frame(input int nsym);
    exp_q.delete();
    bursts_smp.delete();
    bursts_cyc.delete();
    gaps.delete();
    hs_run = 0;
    t_acks = 0; d_acks = 0; done_cnt = 0; busy_gap = 0;
    t_idx = 0; d_idx = 0;
    T_DAT_I = T_BASE;
    D_DAT_I = D_BASE;
    for (int k = 0; k < TRN_SYMS * TRN_LEN; k++) exp_q.push_back(T_BASE | 32'(k));
    for (int k = 0; k < nsym * DAT_LEN; k++)     exp_q.push_back(D_BASE | 32'(k));
  endtask

  task automatic wait_done(input int budget, input int inj);
    bit seen = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      step();
      if (inj != 0 && i == inj) begin
        START_I = 1'b1;
        NSYM_I  = 10'd7;
      end else START_I = 1'b0;
      if (DONE_O === 1'b1) seen = 1;
    end
    in_frame = 0;
    START_I  = 1'b0;
    if (!seen) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input int nsym, input int t_exp, input int d_exp, input bit full);
    chk("burst_count", 32'(bursts_smp.size()), 32'(TRN_SYMS + nsym));
    foreach (bursts_smp[i]) begin
      chk("burst_samples", 32'(bursts_smp[i]), (i < TRN_SYMS) ? 32'(TRN_LEN) : 32'(DAT_LEN));
      if (full) chk("burst_cycles", 32'(bursts_cyc[i]), (i < TRN_SYMS) ? 32'(TRN_LEN) : 32'(DAT_LEN));
    end
    chk("gap_count", 32'(gaps.size()), 32'(TRN_SYMS + nsym - 1));
    foreach (gaps[i]) chk("gap_len", 32'(gaps[i]), 32'(GAP_CYC));
    chk("t_ack_count", 32'(t_acks), 32'(t_exp));
    chk("d_ack_count", 32'(d_acks), 32'(d_exp));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    chk("busy_dropped", 32'(busy_gap), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    rnd = v.rnd;
    begin_frame(v.nsym);
    START_I = 1'b1;
    NSYM_I  = NSYM_W'(v.nsym);
    step();
    START_I  = 1'b0;
    in_frame = 1;
    wait_done(20000, v.inj);
    step();
    check_frame(v.nsym, v.t_exp, v.d_exp, !v.rnd);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{nsym: 3, rnd: 0, inj: 0,   t_exp: 512, d_exp: 576};
    vecs[1] = '{nsym: 0, rnd: 0, inj: 0,   t_exp: 512, d_exp: 0};
    vecs[2] = '{nsym: 2, rnd: 1, inj: 0,   t_exp: 512, d_exp: 384};
    vecs[3] = '{nsym: 1, rnd: 1, inj: 0,   t_exp: 512, d_exp: 192};
    vecs[4] = '{nsym: 1, rnd: 0, inj: 600, t_exp: 512, d_exp: 192};

    RST_I = 1'b1; START_I = 1'b0; NSYM_I = '0;
    T_DAT_I = T_BASE; D_DAT_I = D_BASE;
    T_STB_I = 1'b1; D_STB_I = 1'b1; ACK_I = 1'b1;
    step(); step(); step();
    RST_I = 1'b0;
    step();

    // Idle after reset with both sources requesting: nothing granted
    chk("rst_cyc",   32'(CYC_O),   32'd0);
    chk("rst_busy",  32'(BUSY_O),  32'd0);
    chk("rst_done",  32'(DONE_O),  32'd0);
    chk("rst_stb",   32'(STB_O),   32'd0);
    chk("rst_t_ack", 32'(T_ACK_O), 32'd0);
    chk("rst_d_ack", 32'(D_ACK_O), 32'd0);
    chk("rst_dat",   DAT_O,        32'd0);

    // START together with reset is dropped
    RST_I = 1'b1; START_I = 1'b1; NSYM_I = 10'd1;
    step();
    RST_I = 1'b0; START_I = 1'b0;
    step();
    chk("start_in_rst_busy", 32'(BUSY_O), 32'd0);
    chk("start_in_rst_cyc",  32'(CYC_O),  32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort on reset at sample 100 of the first data symbol
    rnd = 0;
    begin_frame(2);
    START_I = 1'b1; NSYM_I = 10'd2;
    step();
    START_I = 1'b0;
    for (int i = 0; i < 2000 && d_acks < 100; i++) step();
    chk("abort_reached", 32'(d_acks), 32'd100);
    RST_I = 1'b1;
    step();
    RST_I = 1'b0;
    chk("abort_cyc",  32'(CYC_O),  32'd0);
    chk("abort_busy", 32'(BUSY_O), 32'd0);
    chk("abort_stb",  32'(STB_O),  32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_vec('{nsym: 1, rnd: 0, inj: 0, t_exp: 512, d_exp: 192});

    // Back-to-back: START in the DONE cycle
    rnd = 0;
    begin_frame(0);
    START_I = 1'b1; NSYM_I = 10'd0;
    step();
    START_I  = 1'b0;
    in_frame = 1;
    wait_done(20000, 0);
    START_I = 1'b1; NSYM_I = 10'd1;
    step();
    START_I = 1'b0;
    chk("b2b_cyc_rise", 32'(CYC_O),  32'd1);
    chk("b2b_busy",     32'(BUSY_O), 32'd1);
    check_frame(0, 512, 0, 1);
    begin_frame(1);
    in_frame = 1;
    wait_done(20000, 0);
    step();
    check_frame(1, 512, 192, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
